// File: rtl/seq_multdiv_if.sv
// seq_multdiv_if: multiply/divide handshake between the processor (master) and the
// iterative multiplier/divider (slave).
//   data_operandA  [31:0] master->slave  multiplicand / dividend
//   data_operandB  [31:0] master->slave  multiplier / divisor
//   ctrl_MULT             master->slave  one-cycle start-multiply pulse
//   ctrl_DIV              master->slave  one-cycle start-divide pulse
//   data_result    [31:0] slave->master  result, held until next completion
//   data_exception        slave->master  overflow / divide-by-zero flag
//   data_resultRDY        slave->master  one-cycle completion pulse
interface seq_multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/seq_multdiv.sv
// seq_multdiv: signed 32-bit sequential multiplier/divider, one bit per cycle.
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   io_md  slave side of seq_multdiv_if (operands, start pulses, result/exception/RDY)
// A start is accepted in any state; 32 iterations in RUN, then one DONE edge
// publishes the result and pulses data_resultRDY.
module seq_multdiv (
    input  logic         clock,
    input  logic         reset,
    seq_multdiv_if.slave io_md
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      r_state, w_state;
    logic [5:0]  r_count, w_count;
    logic        r_div, w_div;
    logic        r_neg, w_neg;
    logic        r_bzero, w_bzero;
    // r_mag: |A| (added each step) for multiply, |B| (divisor) for divide
    logic [31:0] r_mag, w_mag;
    // {r_hi, r_lo}: product accumulator for multiply; remainder/quotient for divide
    logic [31:0] r_hi, w_hi;
    logic [31:0] r_lo, w_lo;
    logic [31:0] r_result, w_result;
    logic        r_exc, w_exc;
    logic        r_rdy, w_rdy;

    logic        w_start;
    logic [31:0] w_mag_a, w_mag_b;
    logic [32:0] w_sum;
    logic [31:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic        w_mul_ovf;

    assign w_start  = io_md.ctrl_MULT | io_md.ctrl_DIV;
    assign w_mag_a  = io_md.data_operandA[31] ? -io_md.data_operandA : io_md.data_operandA;
    assign w_mag_b  = io_md.data_operandB[31] ? -io_md.data_operandB : io_md.data_operandB;

    // Shift-add step: add multiplicand into the high half when the current multiplier bit is set.
    assign w_sum    = r_lo[0] ? {1'b0, r_hi} + {1'b0, r_mag} : {1'b0, r_hi};

    // Restoring step: the remainder stays below |B| <= 2^31, so the shifted value fits 32 bits.
    assign w_rem_sh = {r_hi[30:0], r_lo[31]};
    assign w_diff   = {1'b0, w_rem_sh} - {1'b0, r_mag};

    assign w_prod    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quot    = r_neg ? -r_lo : r_lo;
    assign w_mul_ovf = !((&w_prod[63:31]) || !(|w_prod[63:31]));

    always_comb begin
        w_state  = r_state;
        w_count  = r_count;
        w_div    = r_div;
        w_neg    = r_neg;
        w_bzero  = r_bzero;
        w_mag    = r_mag;
        w_hi     = r_hi;
        w_lo     = r_lo;
        w_result = r_result;
        w_exc    = r_exc;
        w_rdy    = 1'b0;
        if (r_state == RUN) begin
            w_hi    = r_div ? (w_diff[32] ? w_rem_sh : w_diff[31:0]) : w_sum[32:1];
            w_lo    = r_div ? {r_lo[30:0], ~w_diff[32]} : {w_sum[0], r_lo[31:1]};
            w_count = r_count + 6'd1;
            w_state = (r_count == 6'd31) ? DONE : RUN;
        end
        if (r_state == DONE) begin
            w_rdy    = 1'b1;
            w_state  = IDLE;
            // Only -2^31 / -1 yields a positive quotient magnitude with bit 31 set.
            w_result = r_div ? (r_bzero ? 32'd0 : w_quot) : w_prod[31:0];
            w_exc    = r_div ? (r_bzero | (~r_neg & r_lo[31])) : w_mul_ovf;
        end
        // A start overrides any in-flight op; a DONE on the same edge still publishes.
        if (w_start) begin
            w_state = RUN;
            w_count = 6'd0;
            w_div   = ~io_md.ctrl_MULT;
            w_neg   = io_md.data_operandA[31] ^ io_md.data_operandB[31];
            w_bzero = (io_md.data_operandB == 32'd0);
            w_mag   = io_md.ctrl_MULT ? w_mag_a : w_mag_b;
            w_lo    = io_md.ctrl_MULT ? w_mag_b : w_mag_a;
            w_hi    = 32'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_count  <= 6'd0;
            r_div    <= 1'b0;
            r_neg    <= 1'b0;
            r_bzero  <= 1'b0;
            r_mag    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_count  <= w_count;
            r_div    <= w_div;
            r_neg    <= w_neg;
            r_bzero  <= w_bzero;
            r_mag    <= w_mag;
            r_hi     <= w_hi;
            r_lo     <= w_lo;
            r_result <= w_result;
            r_exc    <= w_exc;
            r_rdy    <= w_rdy;
        end
    end

    assign io_md.data_result    = r_result;
    assign io_md.data_exception = r_exc;
    assign io_md.data_resultRDY = r_rdy;
endmodule

// File: tb/tb_seq_multdiv.sv
// tb_seq_multdiv: directed bench for seq_multdiv covering latency, signed results,
// overflow/divide-by-zero flags, restart and asynchronous reset.
module tb_seq_multdiv;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat;
    int   n;

    seq_multdiv_if md ();

    seq_multdiv dut (
        .clock (clock),
        .reset (reset),
        .io_md (md.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse sampled on the next rising edge, then scramble the operands.
    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        md.data_operandA = a;
        md.data_operandB = b;
        md.ctrl_MULT     = m;
        md.ctrl_DIV      = d;
        @(posedge clock);
        #1;
        md.ctrl_MULT     = 1'b0;
        md.ctrl_DIV      = 1'b0;
        md.data_operandA = ~a;
        md.data_operandB = b ^ 32'h5A5A_A5A5;
    endtask

    // Count RDY pulses over a bounded window; lat is the edge index of the first one (-1 if none).
    task automatic wait_rdy(input int edges, output int first, output int cnt);
        first = -1;
        cnt   = 0;
        for (int i = 1; i <= edges; i++) begin
            @(posedge clock);
            #1;
            if (md.data_resultRDY === 1'b1) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee);
        start(m, d, a, b);
        wait_rdy(40, lat, n);
        check({tag, " latency"}, 32'(lat), 32'd33);
        check({tag, " rdy count"}, 32'(n), 32'd1);
        check({tag, " result"}, md.data_result, er);
        check({tag, " exception"}, {31'd0, md.data_exception}, {31'd0, ee});
    endtask

    initial begin
        md.data_operandA = 32'd0;
        md.data_operandB = 32'd0;
        md.ctrl_MULT     = 1'b0;
        md.ctrl_DIV      = 1'b0;
        #12;
        check("reset result", md.data_result, 32'd0);
        check("reset exception", {31'd0, md.data_exception}, 32'd0);
        check("reset rdy", {31'd0, md.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_op("mul 6x7",          1, 0, 32'd6,          32'd7,          32'h0000_002A, 0);
        do_op("mul -5x3",         1, 0, -32'sd5,        32'd3,          32'hFFFF_FFF1, 0);
        do_op("mul 2^16x2^16",    1, 0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1);
        do_op("mul minint x -1",  1, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1);
        do_op("mul -2^16x2^15",   1, 0, 32'hFFFF_0000,  32'h0000_8000,  32'h8000_0000, 0);
        do_op("div -7/2",         0, 1, -32'sd7,        32'd2,          32'hFFFF_FFFD, 0);
        do_op("div 5/0",          0, 1, 32'd5,          32'd0,          32'h0000_0000, 1);
        do_op("div minint/-1",    0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1);
        do_op("div 100/-7",       0, 1, 32'd100,        -32'sd7,        32'hFFFF_FFF2, 0);
        do_op("mult priority",    1, 1, 32'd6,          32'd7,          32'h0000_002A, 0);

        // Restart: mult 3x4 at k, div 100/7 at k+10; only the div completes, at k+43.
        start(1, 0, 32'd3, 32'd4);
        wait_rdy(9, lat, n);
        check("restart early rdy", 32'(n), 32'd0);
        start(0, 1, 32'd100, 32'd7);
        wait_rdy(40, lat, n);
        check("restart latency", 32'(lat), 32'd33);
        check("restart rdy count", 32'(n), 32'd1);
        check("restart result", md.data_result, 32'h0000_000E);

        // Start on the DONE edge: the finished mult still reports, the div follows 33 edges later.
        start(1, 0, 32'd6, 32'd7);
        wait_rdy(32, lat, n);
        check("overlap early rdy", 32'(n), 32'd0);
        start(0, 1, 32'd100, 32'd7);
        check("overlap rdy", {31'd0, md.data_resultRDY}, 32'd1);
        check("overlap first result", md.data_result, 32'h0000_002A);
        wait_rdy(40, lat, n);
        check("overlap second latency", 32'(lat), 32'd33);
        check("overlap second result", md.data_result, 32'h0000_000E);

        // Asynchronous reset at k+20 clears outputs at once and kills the op.
        do_op("pre-reset mul", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        start(1, 0, 32'h0001_0000, 32'h0001_0000);
        repeat (19) @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async reset result", md.data_result, 32'd0);
        check("async reset exception", {31'd0, md.data_exception}, 32'd0);
        check("async reset rdy", {31'd0, md.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        wait_rdy(40, lat, n);
        check("post-reset no rdy", 32'(n), 32'd0);
        do_op("post-reset div", 0, 1, 32'd12345, 32'd10, 32'h0000_04D2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
